// File: rtl/divider.sv
// Radix-2 restoring divider for DIV/DIVU: WIDTH iterations, then a sign-fix
// cycle that publishes quotient/remainder with a one-cycle done pulse.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_div,
  input  logic             div_sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             div_ready,
  output logic             div_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dz_out;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  assign w_dvd_neg = div_sign & dividend[WIDTH-1];
  assign w_dvs_neg = div_sign & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

  // The release cycle also accepts a new request so back-to-back ops
  // sustain one operation every WIDTH+2 cycles.
  assign w_accept = start_div & ((r_state == S_IDLE) | (r_state == S_DONE));

  // Dividend bits stream out of the quotient register MSB first.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});

  always_comb begin
    w_rem_next = w_shift[WIDTH-1:0];
    if (w_ge) w_rem_next = WIDTH'(w_shift - {1'b0, r_dvs});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_q_out  <= '0;
      r_r_out  <= '0;
      r_dz_out <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_CALC;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
      r_dz    <= (divisor == '0);
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          // Zero divisor leaves the dividend magnitude as remainder, so the
          // normal sign fix restores the original dividend; only q is forced.
          r_q_out  <= r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
          r_r_out  <= r_neg_r ? -r_rem : r_rem;
          r_dz_out <= r_dz;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign div_ready   = r_ready;
  assign div_done    = r_done;
  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dz_out;

endmodule
